// File: rtl/gcd_stream.sv
// Streaming GCD engine: one operand pair at a time, one algorithm step per CALC cycle.
// Supports subtractive Euclid (mode 0) and binary Stein (mode 1) with an iteration count.
module gcd_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [CNT_W-1:0] iter,
    output logic             zero_in
);

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] x, x_n, y, y_n, res_n;
    logic [KW-1:0]    k, k_n;
    logic             m, m_n;
    logic [CNT_W-1:0] iter_n;
    logic             zero_in_n;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            k       <= '0;
            m       <= 1'b0;
            res     <= '0;
            iter    <= '0;
            zero_in <= 1'b0;
        end else begin
            state   <= state_n;
            x       <= x_n;
            y       <= y_n;
            k       <= k_n;
            m       <= m_n;
            res     <= res_n;
            iter    <= iter_n;
            zero_in <= zero_in_n;
        end
    end

    // Every subtraction below is guarded by a comparison, so nothing wraps.
    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        k_n       = k;
        m_n       = m;
        res_n     = res;
        iter_n    = iter;
        zero_in_n = zero_in;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    x_n       = a;
                    y_n       = b;
                    m_n       = mode;
                    k_n       = '0;
                    iter_n    = '0;
                    zero_in_n = (a == '0) || (b == '0);
                    state_n   = CALC;
                end
            end
            CALC: begin
                iter_n = (iter == '1) ? iter : iter + 1'b1;
                if (y == '0) begin
                    res_n   = x << k;
                    state_n = DONE;
                end else if (x == '0) begin
                    res_n   = y << k;
                    state_n = DONE;
                end else if (!m) begin
                    if (x > y) begin
                        x_n = x - y;
                    end else if (x < y) begin
                        y_n = y - x;
                    end else begin
                        y_n = '0;
                    end
                end else begin
                    // Shared factors of two are counted in k and restored when the result is formed.
                    case ({x[0], y[0]})
                        2'b00: begin
                            x_n = x >> 1;
                            y_n = y >> 1;
                            k_n = k + 1'b1;
                        end
                        2'b01: x_n = x >> 1;
                        2'b10: y_n = y >> 1;
                        default: begin
                            if (x >= y) begin
                                x_n = x - y;
                            end else begin
                                y_n = y - x;
                            end
                        end
                    endcase
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/gcd_stream.md
GCD_STREAM -- requirements
Module: gcd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter CNT_W, default 16, iteration-counter width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port a  input  WIDTH  first operand, unsigned.
REQ-008 SHALL have port b  input  WIDTH  second operand, unsigned.
REQ-009 SHALL have port mode  input  1  algorithm select: 0 = subtractive Euclid, 1 = binary (Stein); sampled with operands.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port res  output  WIDTH  gcd(a,b); gcd(x,0)=x; gcd(0,0)=0.
REQ-013 SHALL have port iter  output  CNT_W  number of CALC cycles used, saturating at 2^CNT_W-1.
REQ-014 SHALL have port zero_in  output  1  at least one captured operand was 0.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Input handshake: in_valid & in_ready at an edge SHALL load x<=a, y<=b, m<=mode, k<=0, iter<=0, zero_in<=(a==0 | b==0), and enter CALC.
REQ-017 In CALC each cycle SHALL perform exactly one step and increment iter (saturating), including the final step.
REQ-018 Step, both modes, evaluated in priority order: y==0 -> res<=x<<k, enter DONE; else x==0 -> res<=y<<k, enter DONE.
REQ-019 Step, mode 0, otherwise: x>y -> x<=x-y; x<y -> y<=y-x; x==y -> y<=0.
REQ-020 Step, mode 1, otherwise: x,y both even -> both >>1, k<=k+1; only x even -> x>>1; only y even -> y>>1; both odd -> x>=y ? x<=x-y : y<=y-x.
REQ-021 k SHALL be wide enough to hold WIDTH-1; res SHALL be truncated to WIDTH bits (the shift never overflows for valid gcds).
REQ-022 All arithmetic SHALL be unsigned; subtraction is performed only when the minuend >= subtrahend, so it never wraps.
REQ-023 In DONE, res, iter and zero_in SHALL hold stable; out_ready high at an edge SHALL return the FSM to IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; a new pair SHALL be accepted no earlier than the cycle after the output handshake.
REQ-025 mode, a and b changes during CALC/DONE SHALL NOT affect the computation in flight.
REQ-026 out_valid SHALL remain high until accepted, irrespective of in_valid.

Reset
REQ-027 reset low SHALL immediately (asynchronously) force state=IDLE, x=y=k=0, res=0, iter=0, zero_in=0, so in_ready=1 and out_valid=0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL discard the operation with no result emitted; operation resumes on the first edge after reset deassertion.

Verification
REQ-029 mode=0, a=12, b=8, out_ready=1 -> exactly 4 CALC cycles; res=4, iter=4, zero_in=0; out_valid high for 1 cycle.
REQ-030 mode=1, a=12, b=8 -> 7 CALC cycles; res=4, iter=7; repeat with a=0xFFFFFFFF, b=1, mode=1 -> res=1.
REQ-031 a=0, b=0 and a=0, b=9 (either mode) -> 1 CALC cycle; res=0 and res=9 respectively, iter=1, zero_in=1.
REQ-032 out_ready held low for 10 cycles after completion -> out_valid, res, iter stable; in_ready=0; in_valid pulses ignored.
REQ-033 mode=0, a=0xFFFFFFFF, b=1, CNT_W=16 -> iter saturates at 65535 and res=1 when complete.
REQ-034 reset pulled low 3 cycles into a CALC -> outputs at reset values in the same cycle; no out_valid; the next pair (a=21, b=14, mode 0) -> res=7.
